regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the integer register file.
- Configurable XLEN and register count: 32 for RV32I, 16 for RV32E.
- Single write port with explicit write enable, optional write-to-read bypass, and a hardware clear sequence after reset.
- Per-register pending scoreboard that the decode stage uses for hazard stalls.

Parameters:
- XLEN, 32, data width of every register and data port.
- NREGS, 32, number of architectural registers; legal values are 16 and 32 only.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports; when 0 reads always return array contents.
- ADDR_W (localparam), clog2(NREGS), width of all register selects.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- we_i  in  1  write enable.
- selRd_i  in  ADDR_W  destination register index.
- rd_i  in  XLEN  write data.
- selRs1_i  in  ADDR_W  read port 1 index.
- selRs2_i  in  ADDR_W  read port 2 index.
- rs1_o  out  XLEN  read port 1 data (combinational).
- rs2_o  out  XLEN  read port 2 data (combinational).
- mark_i  in  1  set pending bit of selMark_i (instruction issued).
- selMark_i  in  ADDR_W  register to mark pending.
- rs1_pend_o  out  1  selRs1_i has an outstanding write.
- rs2_pend_o  out  1  selRs2_i has an outstanding write.
- busy_o  out  1  clear sequence running; pipeline must stall.

Behaviour:
- Register array holds indices 1..NREGS-1. x0 is not stored; reads of index 0 return 0 and are never pending.

FSM: states CLEAR and RUN.
- rst_i=1: state<=CLEAR, clear counter cnt<=1, all pending bits<=0. Counter is held at 1 while rst_i stays high.
- CLEAR with rst_i=0: registers[cnt]<=0 and cnt<=cnt+1. When cnt==NREGS-1 is written, state<=RUN.
- Clear time: busy_o=1 for exactly NREGS-1 cycles after the first rst_i=0 edge (31 cycles for NREGS=32, 15 for NREGS=16).
- Outputs during reset and CLEAR: busy_o=1; rs1_o, rs2_o, rs1_pend_o, rs2_pend_o are forced to 0; we_i and mark_i are ignored.
- Reset mid-clear or mid-run: restarts CLEAR from cnt=1; no partial state survives.

Write (RUN):
- we_i=1 and selRd_i!=0: registers[selRd_i]<=rd_i on the clock edge.
- selRd_i==0: write discarded.

Read (RUN):
- rsN_o = 0 if selRsN_i==0.
- Otherwise, with BYPASS=1, rsN_o = rd_i if we_i and selRd_i==selRsN_i.
- Otherwise rsN_o = registers[selRsN_i].
- With BYPASS=0, a read of the register being written returns the old value; the new value is visible from the next cycle.

Scoreboard (RUN), pending bits 1..NREGS-1:
- we_i with selRd_i!=0 clears pending[selRd_i].
- mark_i with selMark_i!=0 sets pending[selMark_i].
- Same index marked and written in one cycle: the set wins, i.e. pending stays 1 for the newly issued instruction.
- rsN_pend_o = pending[selRsN_i] and not (BYPASS and we_i and selRd_i==selRsN_i), and 0 for index 0.
- Pending bits only change on clock edges; no combinational path from mark_i to rsN_pend_o.

General:
- No internal latency beyond the single write edge; read outputs are purely combinational from selects, array and bypass.

Test Plan:
- Reset clear: preload array with 0xDEADBEEF, pulse rst_i 1 cycle, NREGS=32 → busy_o high exactly 31 cycles; afterwards reads of x1..x31 all return 0x00000000.
- Write/read and x0: write 0x12345678 to x5, then 0xFFFFFFFF to x0 → next cycle rs1(x5)=0x12345678 and rs2(x0)=0.
- Bypass: write 0xA5A5A5A5 to x7 while reading x7 on both ports → same cycle rs1_o=rs2_o=0xA5A5A5A5 with BYPASS=1; old value with BYPASS=0.
- Scoreboard: mark x3 → next cycle rs1_pend_o=1 for x3. Write x3 while reading it → pend_o=0 that cycle (BYPASS=1), and pending cleared afterwards. Mark and write x3 in the same cycle → pending remains 1.
- Reset mid-operation and RV32E: with NREGS=16 and ADDR_W=4, assert rst_i at cnt=8 during CLEAR → sequence restarts with busy_o high 15 cycles after release. Writes and marks during busy_o are ignored: x9 reads 0 and is not pending.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file (RV32I / RV32E sizes) with a
// single write port, optional write-to-read bypass, a hardware clear sequence
// after reset and a per-register pending scoreboard for decode hazard stalls.
// x0 is not stored: it always reads as zero and is never pending.
// NREGS is expected to be 16 or 32.
module regfile_sb #(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    parameter int  BYPASS = 1,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] selRd_i,
    input  logic [XLEN-1:0]   rd_i,
    input  logic [ADDR_W-1:0] selRs1_i,
    input  logic [ADDR_W-1:0] selRs2_i,
    output logic [XLEN-1:0]   rs1_o,
    output logic [XLEN-1:0]   rs2_o,
    input  logic              mark_i,
    input  logic [ADDR_W-1:0] selMark_i,
    output logic              rs1_pend_o,
    output logic              rs2_pend_o,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;

    // Data storage for x1..x(NREGS-1); x0 has no storage.
    logic [XLEN-1:0]   regs_q [1:NREGS-1];

    // Pending bits for x1..x(NREGS-1); index 0 is never pending.
    logic [NREGS-1:1]  pend_q;

    // Normal operation: out of reset and past the clear sequence.
    logic run;
    assign run = (state_q == RUN) && !rst_i;

    // Architectural write/mark requests, only honoured while running.
    logic wr_hit;
    logic mark_hit;
    assign wr_hit   = run && we_i   && (selRd_i   != ZERO_IDX);
    assign mark_hit = run && mark_i && (selMark_i != ZERO_IDX);

    // Bypass qualifiers per read port (write data forwarded in the same cycle).
    logic byp1;
    logic byp2;
    assign byp1 = (BYPASS != 0) && wr_hit && (selRd_i == selRs1_i);
    assign byp2 = (BYPASS != 0) && wr_hit && (selRd_i == selRs2_i);

    // Shared write port: driven by the clear counter in CLEAR, by we_i in RUN.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;

    // Control FSM: reset parks in CLEAR with cnt=1, CLEAR walks x1..xN-1 then hands over to RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= ADDR_W'(1);
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q;
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= ADDR_W'(1);
                end
            endcase
        end
    end

    // Write port mux: clear sequence zeroes one register per cycle, otherwise the architectural write.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = selRd_i;
        wr_data = rd_i;
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = '0;
            end else if (wr_hit) begin
                wr_en = 1'b1;
            end
        end
    end

    // Register array update; no reset here, the clear sequence owns initialisation.
    always_ff @(posedge clk_i) begin
        for (int i = 1; i < NREGS; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                regs_q[i] <= wr_data;
            end
        end
    end

    // Scoreboard: a write retires the pending bit, an issue sets it; issue wins on a collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (mark_hit && (selMark_i == ADDR_W'(i))) begin
                    pend_q[i] <= 1'b1;
                end else if (wr_hit && (selRd_i == ADDR_W'(i))) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Array and pending lookups for both read ports (index 0 falls through to zero).
    logic [XLEN-1:0] arr1;
    logic [XLEN-1:0] arr2;
    logic            pnd1;
    logic            pnd2;

    // Read muxes over the stored registers.
    always_comb begin
        arr1 = '0;
        arr2 = '0;
        pnd1 = 1'b0;
        pnd2 = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (selRs1_i == ADDR_W'(i)) begin
                arr1 = regs_q[i];
                pnd1 = pend_q[i];
            end
            if (selRs2_i == ADDR_W'(i)) begin
                arr2 = regs_q[i];
                pnd2 = pend_q[i];
            end
        end
    end

    // Output forming: forced to zero outside RUN, x0 reads zero, bypass overrides the array.
    always_comb begin
        rs1_o      = '0;
        rs2_o      = '0;
        rs1_pend_o = 1'b0;
        rs2_pend_o = 1'b0;
        if (run) begin
            if (selRs1_i != ZERO_IDX) begin
                rs1_o      = byp1 ? rd_i : arr1;
                rs1_pend_o = pnd1 && !byp1;
            end
            if (selRs2_i != ZERO_IDX) begin
                rs2_o      = byp2 ? rd_i : arr2;
                rs2_pend_o = pnd2 && !byp2;
            end
        end
    end

    assign busy_o = rst_i || (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three instances (RV32I with bypass, RV32I without
// bypass, RV32E with bypass) share one stimulus stream and are compared to a
// behavioural model of the register file and scoreboard.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we;
    logic        mark;
    logic [4:0]  sel_rd;
    logic [4:0]  sel_rs1;
    logic [4:0]  sel_rs2;
    logic [4:0]  sel_mark;
    logic [31:0] rd;

    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b, rs1_c, rs2_c;
    logic        p1_a, p2_a, p1_b, p2_b, p1_c, p2_c;
    logic        busy_a, busy_b, busy_c;

    logic [31:0] o_rs1 [3];
    logic [31:0] o_rs2 [3];
    logic        o_p1  [3];
    logic        o_p2  [3];
    logic        o_busy[3];

    assign o_rs1[0] = rs1_a;  assign o_rs1[1] = rs1_b;  assign o_rs1[2] = rs1_c;
    assign o_rs2[0] = rs2_a;  assign o_rs2[1] = rs2_b;  assign o_rs2[2] = rs2_c;
    assign o_p1[0]  = p1_a;   assign o_p1[1]  = p1_b;   assign o_p1[2]  = p1_c;
    assign o_p2[0]  = p2_a;   assign o_p2[1]  = p2_b;   assign o_p2[2]  = p2_c;
    assign o_busy[0] = busy_a; assign o_busy[1] = busy_b; assign o_busy[2] = busy_c;

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .we_i(we), .selRd_i(sel_rd), .rd_i(rd),
        .selRs1_i(sel_rs1), .selRs2_i(sel_rs2), .rs1_o(rs1_a), .rs2_o(rs2_a),
        .mark_i(mark), .selMark_i(sel_mark), .rs1_pend_o(p1_a), .rs2_pend_o(p2_a),
        .busy_o(busy_a)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .we_i(we), .selRd_i(sel_rd), .rd_i(rd),
        .selRs1_i(sel_rs1), .selRs2_i(sel_rs2), .rs1_o(rs1_b), .rs2_o(rs2_b),
        .mark_i(mark), .selMark_i(sel_mark), .rs1_pend_o(p1_b), .rs2_pend_o(p2_b),
        .busy_o(busy_b)
    );

    regfile_sb #(.XLEN(32), .NREGS(16), .BYPASS(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .we_i(we), .selRd_i(sel_rd[3:0]), .rd_i(rd),
        .selRs1_i(sel_rs1[3:0]), .selRs2_i(sel_rs2[3:0]), .rs1_o(rs1_c), .rs2_o(rs2_c),
        .mark_i(mark), .selMark_i(sel_mark[3:0]), .rs1_pend_o(p1_c), .rs2_pend_o(p2_c),
        .busy_o(busy_c)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: per instance register contents, pending flags and
    // the number of clear cycles still to run.
    logic [31:0] mreg [3][32];
    logic        mpend[3][32];
    int          mclr [3];

    function automatic int nr(int m);
        return (m == 2) ? 16 : 32;
    endfunction

    function automatic bit byp(int m);
        return (m != 1);
    endfunction

    function automatic bit exp_busy(int m);
        return rst || (mclr[m] != 0);
    endfunction

    function automatic logic [31:0] exp_rs(int m, logic [4:0] s);
        int i;
        int w;
        i = int'(s) % nr(m);
        w = int'(sel_rd) % nr(m);
        if (exp_busy(m) || i == 0) return 32'h0;
        if (byp(m) && we && w == i) return rd;
        return mreg[m][i];
    endfunction

    function automatic logic exp_pend(int m, logic [4:0] s);
        int i;
        int w;
        i = int'(s) % nr(m);
        w = int'(sel_rd) % nr(m);
        if (exp_busy(m) || i == 0) return 1'b0;
        if (byp(m) && we && w == i) return 1'b0;
        return mpend[m][i];
    endfunction

    function automatic void model_step();
        for (int m = 0; m < 3; m++) begin
            int n;
            int w;
            int k;
            n = nr(m);
            w = int'(sel_rd) % n;
            k = int'(sel_mark) % n;
            if (rst) begin
                mclr[m] = n - 1;
                for (int j = 0; j < 32; j++) mpend[m][j] = 1'b0;
            end else if (mclr[m] != 0) begin
                mclr[m] = mclr[m] - 1;
                if (mclr[m] == 0)
                    for (int j = 0; j < 32; j++) mreg[m][j] = 32'h0;
            end else begin
                if (we && w != 0) begin
                    mreg[m][w]  = rd;
                    mpend[m][w] = 1'b0;
                end
                if (mark && k != 0) mpend[m][k] = 1'b1;
            end
        end
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; mark = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; mark = 1'b1;
        sel_rd = 5'd5; sel_mark = 5'd6; rd = 32'h1;
        sel_rs1 = 5'd5; sel_rs2 = 5'd6;
        step();
        step();
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (o_busy[m] !== 1'b1 || o_rs1[m] !== 32'h0 || o_rs2[m] !== 32'h0 ||
                o_p1[m] !== 1'b0 || o_p2[m] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: busy=%b rs1=%h rs2=%h p1=%b p2=%b, required busy=1 rest 0",
                         m, o_busy[m], o_rs1[m], o_rs2[m], o_p1[m], o_p2[m]);
            end
        end
        idle();
        begin
            int n32;
            int nnb;
            int n16;
            n32 = 0; nnb = 0; n16 = 0;
            for (int c = 0; c < 64; c++) begin
                if (o_busy[0] === 1'b1) n32++;
                if (o_busy[1] === 1'b1) nnb++;
                if (o_busy[2] === 1'b1) n16++;
                if (o_busy[0] === 1'b0 && o_busy[2] === 1'b0) break;
                step();
            end
            checks++;
            if (n32 != 31 || nnb != 31 || n16 != 15) begin
                errors++;
                $display("FAIL clear_length: busy cycles %0d/%0d/%0d, required 31/31/15", n32, nnb, n16);
            end
        end
    endtask

    task automatic test_clear_preload();
        int n;
        idle();
        we = 1'b1; rd = 32'hDEADBEEF;
        for (int i = 1; i < 32; i++) begin
            sel_rd = 5'(i);
            step();
        end
        we = 1'b0;
        sel_rs1 = 5'd17; sel_rs2 = 5'd31;
        #1;
        checks++;
        if (o_rs1[0] !== 32'hDEADBEEF || o_rs2[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL preload: rs1=%h rs2=%h, required deadbeef", o_rs1[0], o_rs2[1]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 64 && o_busy[0] === 1'b1; c++) begin
            n++;
            step();
        end
        checks++;
        if (n != 31) begin
            errors++;
            $display("FAIL preload_clear_length: busy cycles %0d, required 31", n);
        end
        for (int i = 1; i < 32; i++) begin
            sel_rs1 = 5'(i);
            sel_rs2 = 5'(32 - i);
            #1;
            checks++;
            if (o_rs1[0] !== 32'h0 || o_rs2[0] !== 32'h0 || o_rs1[1] !== 32'h0 || o_rs2[1] !== 32'h0) begin
                errors++;
                $display("FAIL cleared_x%0d: rs1=%h/%h rs2=%h/%h, required 0", i,
                         o_rs1[0], o_rs1[1], o_rs2[0], o_rs2[1]);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        we = 1'b1; sel_rd = 5'd5; rd = 32'h12345678;
        step();
        sel_rd = 5'd0; rd = 32'hFFFFFFFF;
        step();
        we = 1'b0;
        sel_rs1 = 5'd5; sel_rs2 = 5'd0;
        #1;
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (o_rs1[m] !== 32'h12345678 || o_rs2[m] !== 32'h0) begin
                errors++;
                $display("FAIL write_read[%0d]: rs1=%h rs2=%h, required 12345678 / 0", m, o_rs1[m], o_rs2[m]);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        we = 1'b1; sel_rd = 5'd7; rd = 32'h11110000;
        step();
        rd = 32'hA5A5A5A5; sel_rs1 = 5'd7; sel_rs2 = 5'd7;
        #1;
        checks++;
        if (o_rs1[0] !== 32'hA5A5A5A5 || o_rs2[0] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_on: rs1=%h rs2=%h, required a5a5a5a5", o_rs1[0], o_rs2[0]);
        end
        checks++;
        if (o_rs1[1] !== 32'h11110000 || o_rs2[1] !== 32'h11110000) begin
            errors++;
            $display("FAIL bypass_off_old: rs1=%h rs2=%h, required 11110000", o_rs1[1], o_rs2[1]);
        end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (o_rs1[1] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_off_new: rs1=%h, required a5a5a5a5", o_rs1[1]);
        end
    endtask

    task automatic test_scoreboard();
        logic [31:0] v;
        idle();
        v = $urandom;
        mark = 1'b1; sel_mark = 5'd3; sel_rs1 = 5'd3; sel_rs2 = 5'd3;
        #1;
        checks++;
        if (o_p1[0] !== 1'b0) begin
            errors++;
            $display("FAIL mark_no_comb_path: pend=%b, required 0", o_p1[0]);
        end
        step();
        mark = 1'b0;
        #1;
        checks++;
        if (o_p1[0] !== 1'b1 || o_p2[0] !== 1'b1 || o_p1[2] !== 1'b1) begin
            errors++;
            $display("FAIL mark_pending: pend=%b/%b/%b, required 1", o_p1[0], o_p2[0], o_p1[2]);
        end
        we = 1'b1; sel_rd = 5'd3; rd = v;
        #1;
        checks++;
        if (o_p1[0] !== 1'b0 || o_p1[1] !== 1'b1 || o_rs1[0] !== v) begin
            errors++;
            $display("FAIL write_pending: pend=%b/%b rs1=%h, required 0/1 %h", o_p1[0], o_p1[1], o_rs1[0], v);
        end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (o_p1[0] !== 1'b0 || o_p1[1] !== 1'b0) begin
            errors++;
            $display("FAIL pending_cleared: pend=%b/%b, required 0/0", o_p1[0], o_p1[1]);
        end
        mark = 1'b1; sel_mark = 5'd3; we = 1'b1; sel_rd = 5'd3;
        step();
        idle();
        #1;
        checks++;
        if (o_p1[0] !== 1'b1 || o_p1[1] !== 1'b1) begin
            errors++;
            $display("FAIL mark_wins: pend=%b/%b, required 1/1", o_p1[0], o_p1[1]);
        end
        we = 1'b1;
        step();
        idle();
    endtask

    task automatic test_rv32e_midclear();
        int n;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (7) step();
        checks++;
        if (o_busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL midclear_busy: busy=%b, required 1", o_busy[2]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        we = 1'b1; sel_rd = 5'd9; rd = 32'hCAFEF00D; mark = 1'b1; sel_mark = 5'd9;
        n = 0;
        for (int c = 0; c < 64 && o_busy[2] === 1'b1; c++) begin
            n++;
            step();
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL rv32e_restart_length: busy cycles %0d, required 15", n);
        end
        idle();
        sel_rs1 = 5'd9;
        #1;
        checks++;
        if (o_rs1[2] !== 32'h0 || o_p1[2] !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignores_ops: rs1=%h pend=%b, required 0/0", o_rs1[2], o_p1[2]);
        end
        for (int c = 0; c < 64 && o_busy[0] === 1'b1; c++) step();
        checks++;
        if (o_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL rv32i_clear_timeout: busy=%b, required 0", o_busy[0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 600; it++) begin
            rst      = ($urandom_range(0, 99) == 0);
            we       = $urandom_range(0, 1);
            mark     = ($urandom_range(0, 2) == 0);
            sel_rd   = 5'($urandom_range(0, 31));
            sel_mark = 5'($urandom_range(0, 31));
            sel_rs1  = ($urandom_range(0, 3) == 0) ? sel_rd : 5'($urandom_range(0, 31));
            sel_rs2  = ($urandom_range(0, 3) == 0) ? sel_mark : 5'($urandom_range(0, 31));
            rd       = $urandom;
            #1;
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (o_rs1[m] !== exp_rs(m, sel_rs1) || o_rs2[m] !== exp_rs(m, sel_rs2) ||
                    o_p1[m] !== exp_pend(m, sel_rs1) || o_p2[m] !== exp_pend(m, sel_rs2) ||
                    o_busy[m] !== exp_busy(m)) begin
                    errors++;
                    $display("FAIL random[%0d] it=%0d: rs1=%h rs2=%h p=%b%b busy=%b, required rs1=%h rs2=%h p=%b%b busy=%b",
                             m, it, o_rs1[m], o_rs2[m], o_p1[m], o_p2[m], o_busy[m],
                             exp_rs(m, sel_rs1), exp_rs(m, sel_rs2),
                             exp_pend(m, sel_rs1), exp_pend(m, sel_rs2), exp_busy(m));
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        for (int m = 0; m < 3; m++) mclr[m] = 0;
        rst = 1'b0; we = 1'b0; mark = 1'b0;
        sel_rd = '0; sel_rs1 = '0; sel_rs2 = '0; sel_mark = '0; rd = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_clear_preload();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_rv32e_midclear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
